// File: rtl/weight_preload_pkg.sv
// weight_preload_pkg: shared state type and default sizes
// for the weight preload sequencer.
package weight_preload_pkg;

   localparam int unsigned ADDR_W_D = 10;
   localparam int unsigned KSIZE_D  = 5;
   localparam int unsigned RD_LAT_D = 1;
   localparam int unsigned KCNT_W_D = 8;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAIN,
      VALID,
      FINISH
   } state_t;

endpackage

// File: rtl/rd_lat_pipe.sv
// rd_lat_pipe: DEPTH-deep 1-bit delay line with sync flush.
// Ports: clk, rst_n, i_flush (clear line), i_d (in), o_q (delayed out).
module rd_lat_pipe #(
   parameter int unsigned DEPTH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_flush,
   input  logic i_d,
   output logic o_q
);

   logic [DEPTH-1:0] r_sr;

   if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)       r_sr <= '0;
         else if (i_flush) r_sr <= '0;
         else              r_sr <= i_d;
      end
   end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)       r_sr <= '0;
         else if (i_flush) r_sr <= '0;
         else              r_sr <= {r_sr[DEPTH-2:0], i_d};
      end
   end

   assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/weight_preload_ctrl.sv
// weight_preload_ctrl: per-kernel BRAM read sequencer for the
// KSIZE-column weight preload shift register.
// Ports: i_start/i_abort control, i_base_addr/i_num_kernels job,
// i_weight_ack from PE array; o_bram_en/o_bram_addr to BRAM,
// o_load_weight_preload shift enable, o_weight_valid, o_kernel_idx,
// o_busy, o_done (1-cycle pulse).
module weight_preload_ctrl
   import weight_preload_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_D,
   parameter int unsigned KSIZE  = KSIZE_D,
   parameter int unsigned RD_LAT = RD_LAT_D,
   parameter int unsigned KCNT_W = KCNT_W_D
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [KCNT_W-1:0] i_num_kernels,
   input  logic              i_weight_ack,
   output logic              o_bram_en,
   output logic [ADDR_W-1:0] o_bram_addr,
   output logic              o_load_weight_preload,
   output logic              o_weight_valid,
   output logic [KCNT_W-1:0] o_kernel_idx,
   output logic              o_busy,
   output logic              o_done
);

   localparam int unsigned CW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
   localparam int unsigned DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(KSIZE - 1);
   localparam logic [DW-1:0] DRN_LAST = DW'(RD_LAT - 1);

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [CW-1:0]     r_col;
   logic [DW-1:0]     r_drain;
   logic [KCNT_W-1:0] r_kidx;
   logic [KCNT_W-1:0] r_nk;
   logic              w_col_last;
   logic              w_drn_last;
   logic              w_last_k;

   assign w_col_last = (r_col == COL_LAST);
   assign w_drn_last = (r_drain == DRN_LAST);
   assign w_last_k   = (r_kidx == r_nk - KCNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (i_start)
               w_next = (i_num_kernels == '0) ? FINISH : FETCH;
         end
         FETCH:  if (w_col_last) w_next = DRAIN;
         // DRAIN lasts RD_LAT cycles: the last in-flight read
         // shifts in on the final DRAIN cycle.
         DRAIN:  if (w_drn_last) w_next = VALID;
         VALID: begin
            if (i_weight_ack)
               w_next = w_last_k ? FINISH : FETCH;
         end
         FINISH: w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (i_abort) w_next = IDLE;
   end

   // Kernels are contiguous, so the address simply increments
   // on every read and wraps at 2^ADDR_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_col   <= '0;
         r_drain <= '0;
         r_kidx  <= '0;
         r_nk    <= '0;
      end else if (i_abort) begin
         r_col   <= '0;
         r_drain <= '0;
         r_kidx  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_addr <= i_base_addr;
                  r_nk   <= i_num_kernels;
                  r_kidx <= '0;
               end
            end
            FETCH: begin
               r_addr <= r_addr + ADDR_W'(1);
               r_col  <= w_col_last ? '0 : r_col + CW'(1);
            end
            DRAIN: begin
               r_drain <= w_drn_last ? '0 : r_drain + DW'(1);
            end
            VALID: begin
               if (i_weight_ack && !w_last_k)
                  r_kidx <= r_kidx + KCNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   rd_lat_pipe #(
      .DEPTH (RD_LAT)
   ) u_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (i_abort),
      .i_d     (o_bram_en),
      .o_q     (o_load_weight_preload)
   );

   assign o_bram_en      = (r_state == FETCH);
   assign o_bram_addr    = r_addr;
   assign o_weight_valid = (r_state == VALID);
   assign o_kernel_idx   = r_kidx;
   assign o_busy         = (r_state != IDLE);
   assign o_done         = (r_state == FINISH);

endmodule

// File: tb/tb_weight_preload_ctrl.sv
// tb_weight_preload_ctrl: randomized check of two builds (RD_LAT 1
// and 3) against a timeline model, a BRAM and a preload register.
module tb_weight_preload_ctrl;

   localparam int AW = 10;
   localparam int KW = 8;
   localparam int K  = 5;
   localparam int CB = 5;
   localparam int L0 = 1;
   localparam int L1 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          start;
   logic          abort;
   logic          ack;
   logic [AW-1:0] base;
   logic [KW-1:0] nk;
   logic          en   [2];
   logic          ld   [2];
   logic          vld  [2];
   logic          bsy  [2];
   logic          dn   [2];
   logic [AW-1:0] addr [2];
   logic [KW-1:0] kidx [2];

   logic [CB-1:0]   mem [1024];
   logic [CB-1:0]   dp  [2][3];
   logic [K*CB-1:0] pre [2];

   int n_chk = 0;
   int n_err = 0;
   int c = 0;

   // model: fs = cycle of first read of current kernel
   int fs [2];
   int kk [2];
   int nkl [2];
   int bl [2];
   int done_at [2];
   int kim [2];
   bit run [2];

   weight_preload_ctrl #(
      .ADDR_W (AW), .KSIZE (K), .RD_LAT (L0), .KCNT_W (KW)
   ) u0 (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .i_start               (start),
      .i_abort               (abort),
      .i_base_addr           (base),
      .i_num_kernels         (nk),
      .i_weight_ack          (ack),
      .o_bram_en             (en[0]),
      .o_bram_addr           (addr[0]),
      .o_load_weight_preload (ld[0]),
      .o_weight_valid        (vld[0]),
      .o_kernel_idx          (kidx[0]),
      .o_busy                (bsy[0]),
      .o_done                (dn[0])
   );

   weight_preload_ctrl #(
      .ADDR_W (AW), .KSIZE (K), .RD_LAT (L1), .KCNT_W (KW)
   ) u1 (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .i_start               (start),
      .i_abort               (abort),
      .i_base_addr           (base),
      .i_num_kernels         (nk),
      .i_weight_ack          (ack),
      .o_bram_en             (en[1]),
      .o_bram_addr           (addr[1]),
      .o_load_weight_preload (ld[1]),
      .o_weight_valid        (vld[1]),
      .o_kernel_idx          (kidx[1]),
      .o_busy                (bsy[1]),
      .o_done                (dn[1])
   );

   function automatic int lat(input int i);
      return (i == 0) ? L0 : L1;
   endfunction

   // BRAM with per-build read latency feeding the preload register
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         dp[i][0] <= mem[addr[i]];
         dp[i][1] <= dp[i][0];
         dp[i][2] <= dp[i][1];
         if (ld[i])
            pre[i] <= {dp[i][lat(i)-1], pre[i][K*CB-1:CB]};
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, c);
      end
   endtask

   function automatic bit m_vld(input int i);
      return run[i] && (c >= fs[i] + K + lat(i));
   endfunction

   function automatic bit m_busy(input int i);
      return run[i] || (c == done_at[i]);
   endfunction

   function automatic logic [K*CB-1:0] exp_kern(input int i);
      logic [K*CB-1:0] v;
      v = '0;
      for (int j = 0; j < K; j++)
         v[j*CB +: CB] = mem[(bl[i] + kk[i]*K + j) & 1023];
      return v;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 2; i++) begin
         run[i] = 0;
         fs[i] = -1000;
         done_at[i] = -1;
         kim[i] = 0;
         kk[i] = 0;
         nkl[i] = 0;
         bl[i] = 0;
      end
   endtask

   task automatic check_now();
      for (int i = 0; i < 2; i++) begin
         int l;
         bit e_en, e_ld, e_vld, e_dn;
         l = lat(i);
         e_en = (c >= fs[i]) && (c < fs[i] + K);
         e_ld = (c >= fs[i] + l) && (c < fs[i] + K + l);
         e_vld = m_vld(i);
         e_dn = (c == done_at[i]);
         check($sformatf("bram_en%0d", i), en[i], e_en);
         check($sformatf("load%0d", i), ld[i], e_ld);
         check($sformatf("valid%0d", i), vld[i], e_vld);
         check($sformatf("done%0d", i), dn[i], e_dn);
         check($sformatf("busy%0d", i), bsy[i], m_busy(i));
         check($sformatf("kidx%0d", i), kidx[i], kim[i]);
         if (e_en)
            check($sformatf("addr%0d", i), addr[i],
                  (bl[i] + kk[i]*K + (c - fs[i])) & 1023);
         if (e_vld)
            check($sformatf("preload%0d", i), pre[i], exp_kern(i));
      end
   endtask

   task automatic m_update(input bit s, input bit a, input bit k);
      for (int i = 0; i < 2; i++) begin
         if (a) begin
            run[i] = 0;
            fs[i] = -1000;
            done_at[i] = -1;
            kim[i] = 0;
         end else if (!m_busy(i)) begin
            if (s) begin
               bl[i] = base;
               nkl[i] = nk;
               kk[i] = 0;
               kim[i] = 0;
               if (nk == 0) done_at[i] = c + 1;
               else begin
                  run[i] = 1;
                  fs[i] = c + 1;
               end
            end
         end else if (m_vld(i) && k) begin
            if (kk[i] == nkl[i] - 1) begin
               run[i] = 0;
               fs[i] = -1000;
               done_at[i] = c + 1;
            end else begin
               kk[i]++;
               kim[i]++;
               fs[i] = c + 1;
            end
         end
      end
   endtask

   task automatic tick(input bit s, input bit a, input bit k);
      check_now();
      start = s;
      abort = a;
      ack = k;
      m_update(s, a, k);
      @(posedge clk);
      #1;
      c++;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(0, 0, 0);
   endtask

   task automatic wait_ack(input int hold);
      int n;
      n = 0;
      while (!(m_vld(0) && m_vld(1)) && n < 200) begin
         tick(0, 0, 0);
         n++;
      end
      if (n >= 200) check("timeout_valid", 0, 1);
      repeat (hold) tick(0, 0, 0);
      tick(0, 0, 1);
   endtask

   task automatic check_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_en%0d", tag, i), en[i], 0);
         check($sformatf("%s_ld%0d", tag, i), ld[i], 0);
         check($sformatf("%s_vld%0d", tag, i), vld[i], 0);
         check($sformatf("%s_busy%0d", tag, i), bsy[i], 0);
         check($sformatf("%s_done%0d", tag, i), dn[i], 0);
         check($sformatf("%s_kidx%0d", tag, i), kidx[i], 0);
         check($sformatf("%s_addr%0d", tag, i), addr[i], 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      ack = 1'b0;
      base = '0;
      nk = '0;
      for (int a = 0; a < 1024; a++) mem[a] = CB'($urandom);
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;

      // single kernel; start+ack together in IDLE
      base = 10'h010;
      nk = 8'd1;
      tick(1, 0, 1);
      wait_ack(2);
      idle(4);

      // wrapping addresses, stray ack, start while busy, long hold
      base = 10'h3FD;
      nk = 8'd3;
      tick(1, 0, 0);
      tick(0, 0, 1);
      base = 10'h000;
      tick(1, 0, 0);
      wait_ack(0);
      wait_ack(20);
      wait_ack(1);
      idle(4);

      // zero kernels
      base = AW'($urandom);
      nk = 8'd0;
      tick(1, 0, 0);
      idle(3);

      // abort in FETCH column 2
      base = 10'h100;
      nk = 8'd2;
      tick(1, 0, 0);
      idle(2);
      tick(0, 1, 0);
      idle(5);

      // abort in DRAIN
      nk = 8'd1;
      tick(1, 0, 0);
      idle(5);
      tick(0, 1, 0);
      idle(4);

      // fresh start after aborts
      base = AW'($urandom);
      nk = 8'd2;
      tick(1, 0, 0);
      wait_ack(0);
      wait_ack(3);
      idle(3);

      // randomized jobs
      for (int t = 0; t < 40; t++) begin
         int n;
         bit s, a, k;
         base = AW'($urandom);
         nk = KW'($urandom_range(0, 4));
         tick(1, 0, 0);
         n = 0;
         while ((m_busy(0) || m_busy(1)) && n < 600) begin
            s = m_busy(0) && m_busy(1) && ($urandom % 8 == 0);
            a = ($urandom % 100 == 0);
            k = ($urandom % 3 == 0);
            tick(s, a, k);
            n++;
         end
         if (n >= 600) check("timeout_job", 0, 1);
         idle(2);
      end

      // async reset while loading
      base = AW'($urandom);
      nk = 8'd2;
      tick(1, 0, 0);
      idle(3);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("areset");
      m_reset();
      start = 1'b0;
      abort = 1'b0;
      ack = 1'b0;
      @(posedge clk);
      #1;
      c++;
      rst_n = 1'b1;
      idle(2);
      nk = 8'd1;
      tick(1, 0, 0);
      wait_ack(0);
      idle(3);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
